// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side consumers.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  res;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAPT = 3'd1,
        EXEC = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } exec_state_t;

    localparam int ORDER_INC = 0;
    localparam int ORDER_DEC = 1;

endpackage

// File: rtl/instr_alu.sv
// Combinational reference ALU: recomputes an instruction result from opcode
// and signed operands. Division by zero and unknown opcodes yield zero.
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opcode,
    input  operand_t a,
    input  operand_t b,
    output result_t  result
);

    result_t a_ext;
    result_t b_ext;

    // Operands are widened to 64 bits so the product is exact.
    assign a_ext = result_t'(a);
    assign b_ext = result_t'(b);

    // Opcode decode; SV signed / and % truncate toward zero with the
    // remainder taking the dividend's sign, which is the intended behaviour.
    always_comb begin
        result = '0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV:   if (b != '0) result = a_ext / b_ext;
            MOD:   if (b != '0) result = a_ext % b_ext;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_reader.sv
// Read-side master for the instruction register: walks an address range,
// captures each word, recomputes its result and streams it out with a
// mismatch flag against the stored result field.
module instr_exec_reader
    import instr_register_pkg::*;
#(
    parameter int READ_ORDER = ORDER_INC,
    parameter int CNT_W      = 6,
    parameter int ERR_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  address_t           first_addr,
    input  logic [CNT_W-1:0]   count,
    output address_t           read_pointer,
    input  instruction_t       instruction_word,
    output logic               res_valid,
    input  logic               res_ready,
    output address_t           res_addr,
    output opcode_t            res_opcode,
    output result_t            res_value,
    output logic               res_mismatch,
    output logic               busy,
    output logic               done,
    output logic [ERR_W-1:0]   mismatch_count
);

    exec_state_t  state;
    exec_state_t  next_state;
    logic [5:0]   remaining;
    instruction_t captured;
    result_t      alu_result;
    logic         mismatch;
    address_t     next_pointer;

    // Requests beyond the register depth are limited to one full sweep.
    function automatic logic [5:0] clamp_count(input logic [CNT_W-1:0] c);
        if (32'(c) > 32'd32) return 6'd32;
        else                 return 6'(c);
    endfunction

    // The mismatch counter sticks at all-ones rather than wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (&v) return v;
        else    return v + ERR_W'(1);
    endfunction

    instr_alu u_alu (
        .opcode (captured.opc),
        .a      (captured.op_a),
        .b      (captured.op_b),
        .result (alu_result)
    );

    assign mismatch     = (alu_result != captured.res);
    assign next_pointer = (READ_ORDER == ORDER_DEC) ? read_pointer - 5'd1
                                                    : read_pointer + 5'd1;

    // State register; reset abandons any run without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode plus the busy/done status outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = (count == '0) ? DONE : CAPT;
            end
            CAPT: begin
                busy       = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                busy       = 1'b1;
                next_state = OUT;
            end
            OUT: begin
                busy = 1'b1;
                if (res_ready) next_state = (remaining > 6'd1) ? CAPT : DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address walk, word capture, result beat registers and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_pointer   <= 5'h1F;
            remaining      <= '0;
            captured       <= '0;
            res_valid      <= 1'b0;
            res_addr       <= '0;
            res_opcode     <= ZERO;
            res_value      <= '0;
            res_mismatch   <= 1'b0;
            mismatch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mismatch_count <= '0;
                        if (count != '0) begin
                            read_pointer <= first_addr;
                            remaining    <= clamp_count(count);
                        end
                    end
                end
                CAPT: captured <= instruction_word;
                EXEC: begin
                    res_addr     <= read_pointer;
                    res_opcode   <= captured.opc;
                    res_value    <= alu_result;
                    res_mismatch <= mismatch;
                    res_valid    <= 1'b1;
                    if (mismatch) mismatch_count <= sat_inc(mismatch_count);
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        remaining <= remaining - 6'd1;
                        if (remaining > 6'd1) read_pointer <= next_pointer;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_reader.sv
// Directed bench for instr_exec_reader: one incrementing and one
// decrementing instance share a modelled register file.
module tb_instr_exec_reader;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sel = 1'b0;
    address_t     first_addr = '0;
    logic [5:0]   count = '0;
    logic         res_ready = 1'b1;
    instruction_t regs [32];

    address_t     i_rp, d_rp, i_addr, d_addr, o_rp, o_addr;
    instruction_t i_word, d_word;
    logic         i_valid, d_valid, o_valid;
    opcode_t      i_opc, d_opc, o_opc;
    result_t      i_val, d_val, o_val;
    logic         i_mis, d_mis, o_mis;
    logic         i_busy, d_busy, o_busy;
    logic         i_done, d_done, o_done;
    logic [15:0]  i_mc, d_mc, o_mc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign i_word = regs[i_rp];
    assign d_word = regs[d_rp];

    instr_exec_reader #(.READ_ORDER(0), .CNT_W(6), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start & ~sel), .first_addr(first_addr),
        .count(count), .read_pointer(i_rp), .instruction_word(i_word),
        .res_valid(i_valid), .res_ready(res_ready), .res_addr(i_addr),
        .res_opcode(i_opc), .res_value(i_val), .res_mismatch(i_mis),
        .busy(i_busy), .done(i_done), .mismatch_count(i_mc)
    );

    instr_exec_reader #(.READ_ORDER(1), .CNT_W(6), .ERR_W(16)) dut_dec (
        .clk(clk), .reset(reset), .start(start & sel), .first_addr(first_addr),
        .count(count), .read_pointer(d_rp), .instruction_word(d_word),
        .res_valid(d_valid), .res_ready(res_ready), .res_addr(d_addr),
        .res_opcode(d_opc), .res_value(d_val), .res_mismatch(d_mis),
        .busy(d_busy), .done(d_done), .mismatch_count(d_mc)
    );

    assign o_rp    = sel ? d_rp    : i_rp;
    assign o_valid = sel ? d_valid : i_valid;
    assign o_addr  = sel ? d_addr  : i_addr;
    assign o_opc   = sel ? d_opc   : i_opc;
    assign o_val   = sel ? d_val   : i_val;
    assign o_mis   = sel ? d_mis   : i_mis;
    assign o_busy  = sel ? d_busy  : i_busy;
    assign o_done  = sel ? d_done  : i_done;
    assign o_mc    = sel ? d_mc    : i_mc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic s, input address_t fa, input logic [5:0] cnt);
        sel        = s;
        first_addr = fa;
        count      = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input address_t a, input opcode_t op,
                               input result_t v, input logic m);
        int n = 0;
        tick();
        while (!o_valid && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(o_valid), 64'(1'b1));
        chk({tag, "_addr"},  64'(o_addr),  64'(a));
        chk({tag, "_opc"},   64'(o_opc),   64'(op));
        chk({tag, "_value"}, o_val,        v);
        chk({tag, "_mis"},   64'(o_mis),   64'(m));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!o_done && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(o_done), 64'(1'b1));
        tick();
        chk({tag, "_done_pulse"}, 64'(o_done), 64'(1'b0));
        chk({tag, "_idle"},       64'(o_busy), 64'(1'b0));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[0]  = '{opc: ADD,   op_a: 5,   op_b: 3,  res: 8};
        regs[1]  = '{opc: SUB,   op_a: -7,  op_b: 2,  res: -9};
        regs[2]  = '{opc: MULT,  op_a: -15, op_b: 15, res: -225};
        regs[4]  = '{opc: DIV,   op_a: 9,   op_b: 0,  res: 5};
        regs[5]  = '{opc: MOD,   op_a: -7,  op_b: 2,  res: -1};
        regs[6]  = '{opc: PASSB, op_a: 1,   op_b: -3, res: -3};
        regs[7]  = '{opc: ZERO,  op_a: 5,   op_b: 5,  res: 0};
        regs[31] = '{opc: PASSA, op_a: 42,  op_b: 7,  res: 42};

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_rp",    64'(o_rp),    64'(5'h1F));
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_addr",  64'(o_addr),  64'(0));
        chk("rst_opc",   64'(o_opc),   64'(ZERO));
        chk("rst_value", o_val,        64'(0));
        chk("rst_mis",   64'(o_mis),   64'(0));
        chk("rst_busy",  64'(o_busy),  64'(0));
        chk("rst_done",  64'(o_done),  64'(0));
        chk("rst_mc",    64'(o_mc),    64'(0));
        reset = 1'b0;
        tick();

        // Incrementing run over 0..2
        run(1'b0, 5'd0, 6'd3);
        chk("t1_busy", 64'(o_busy), 64'(1));
        expect_beat("t1_b0", 5'd0, ADD,  64'sd8,    1'b0);
        expect_beat("t1_b1", 5'd1, SUB,  -64'sd9,   1'b0);
        expect_beat("t1_b2", 5'd2, MULT, -64'sd225, 1'b0);
        wait_done("t1");
        chk("t1_mc", 64'(o_mc), 64'(0));
        chk("t1_rp", 64'(o_rp), 64'(2));

        // Decrementing run with wrap 1,0,31
        run(1'b1, 5'd1, 6'd3);
        expect_beat("t2_b0", 5'd1,  SUB,   -64'sd9, 1'b0);
        expect_beat("t2_b1", 5'd0,  ADD,   64'sd8,  1'b0);
        expect_beat("t2_b2", 5'd31, PASSA, 64'sd42, 1'b0);
        wait_done("t2");
        chk("t2_rp", 64'(o_rp), 64'(31));

        // Divide by zero mismatch and signed modulo
        run(1'b0, 5'd4, 6'd2);
        expect_beat("t3_b0", 5'd4, DIV, 64'sd0,  1'b1);
        chk("t3_mc_b0", 64'(o_mc), 64'(1));
        expect_beat("t3_b1", 5'd5, MOD, -64'sd1, 1'b0);
        wait_done("t3");
        chk("t3_mc", 64'(o_mc), 64'(1));

        // Zero-length run: done one cycle later, counter cleared
        run(1'b0, 5'd9, 6'd0);
        chk("t5_done_now", 64'(o_done),  64'(1));
        chk("t5_novalid",  64'(o_valid), 64'(0));
        chk("t5_mc_clr",   64'(o_mc),    64'(0));
        wait_done("t5");

        // Consumer stall on the first beat
        res_ready = 1'b0;
        run(1'b0, 5'd6, 6'd2);
        expect_beat("t4_b0", 5'd6, PASSB, -64'sd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_valid", 64'(o_valid), 64'(1));
            chk("t4_hold_addr",  64'(o_addr),  64'(6));
            chk("t4_hold_value", o_val,        -64'sd3);
            chk("t4_hold_rp",    64'(o_rp),    64'(6));
        end
        res_ready = 1'b1;
        expect_beat("t4_b1", 5'd7, ZERO, 64'sd0, 1'b0);
        wait_done("t4");

        // Start while busy is ignored
        run(1'b0, 5'd0, 6'd2);
        expect_beat("t6_b0", 5'd0, ADD, 64'sd8, 1'b0);
        first_addr = 5'd10;
        count      = 6'd5;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        chk("t6_busy", 64'(o_busy), 64'(1));
        chk("t6_rp",   64'(o_rp),   64'(1));
        expect_beat("t6_b1", 5'd1, SUB, -64'sd9, 1'b0);
        wait_done("t6");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_extra", 64'(o_valid | o_busy), 64'(0));
        end

        // Reset while a beat is pending
        run(1'b0, 5'd0, 6'd3);
        expect_beat("t7_b0", 5'd0, ADD, 64'sd8, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_valid", 64'(o_valid), 64'(0));
        chk("t7_busy",  64'(o_busy),  64'(0));
        chk("t7_rp",    64'(o_rp),    64'(31));
        chk("t7_done",  64'(o_done),  64'(0));
        tick();
        chk("t7_done2", 64'(o_done),  64'(0));
        run(1'b0, 5'd2, 6'd1);
        expect_beat("t7_b1", 5'd2, MULT, -64'sd225, 1'b0);
        wait_done("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
